filter_bist: RTL and testbench
==============================

# filter_bist

Synthesizable built-in self-test sequencer for the IIR filter datapath. It is the on-chip, parametrised successor of the filter's simulation bench. It holds loadable stimulus and reference sample memories, plays the stimulus into the filter's input sample by sample, and compares the filter output against the reference with a configurable pipeline latency. It reports pass/fail, a saturating mismatch count and the index of the first mismatch. It sits beside `filter_top`, muxed onto its `in` port in test mode.

## Interface
Parameters:
- `DATA_W`, 11: sample width, two's complement, for stimulus, reference, `dut_in` and `dut_out`.
- `DEPTH`, 128: entries in each memory; must be ≥ 2.
- `LATENCY`, 6: filter latency in `clk` cycles; 0 ≤ `LATENCY` < `DEPTH`.
- `ERR_W`, 16: width of the mismatch counter.
- `FLUSH_LEN`, 25: zero-input cycles before the run; used only with `FILTER_BIST_FLUSH_EN`.
- `AW`, `$clog2(DEPTH+LATENCY)`: derived width of the index/address fields.

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `load_en`  in  1  memory write strobe.
- `load_sel`  in  1  memory select: 0 = stimulus, 1 = reference.
- `load_addr`  in  AW  write address; values ≥ `DEPTH` are ignored.
- `load_data`  in  DATA_W  write data.
- `start`  in  1  single-cycle run request.
- `dut_in`  out  DATA_W  registered sample driven to the filter.
- `dut_out`  in  DATA_W  filter output.
- `busy`  out  1  high from the cycle after `start` is accepted until `done`.
- `done`  out  1  one-cycle pulse at the end of a run.
- `pass`  out  1  result of the last completed run.
- `err_count`  out  ERR_W  saturating count of mismatches.
- `first_err_idx`  out  AW  compare index of the first mismatch.

## Operation
- States: IDLE, FLUSH (only when the macro is defined), RUN, DONE.
- Reset values: state IDLE; `dut_in` 0; `busy` 0; `done` 0; `pass` 0; `err_count` 0; `first_err_idx` all-ones. Memory contents are not reset.
- IDLE: a `load_en` write is accepted. `start`=1 moves to FLUSH or RUN. On that edge, clear `err_count`, set `first_err_idx` to all-ones, clear `pass`, set compare index j=0.
- RUN: lasts `DEPTH+LATENCY` cycles, with j incrementing by 1 per cycle.
  - Sample driven: `dut_in` = `stim[j]` for j < `DEPTH`, else 0.
  - Expected value: `exp(j)` = 0 for j < `LATENCY`, else `ref[j-LATENCY]`.
- Compare rule: in the cycle where `dut_in` holds the sample for index j, `dut_out` is compared with `exp(j)`. On inequality:
  - `err_count` increments, saturating at all-ones.
  - `first_err_idx` loads j if it is still all-ones.
- DONE: lasts one cycle. `done`=1 and `busy`=0. `pass` loads (`err_count`==0 after the final compare). `dut_in` is 0. Returns to IDLE.
- `pass`, `err_count` and `first_err_idx` hold until the next accepted `start`.
- While `busy`=1, `start` and `load_en` are ignored.
- Arithmetic: the comparison is a full-width bit compare; there is no tolerance window.

## Timing
- `start` is sampled at edge E0.
- The first RUN cycle (j=0) begins at E0, or at E0+`FLUSH_LEN` with flush enabled.
- `dut_in`=`stim[0]` is valid after the first RUN edge; `busy` rises at E0.
- `done` is asserted `DEPTH+LATENCY` cycles after RUN begins. With the defaults (no flush) that is 134 cycles after E0.
- Back-to-back runs: `start` in the DONE cycle is ignored. `start` in the following IDLE cycle is accepted.
- A mid-run `reset` aborts immediately to the reset values; the memories keep their contents.
- If `err_count` saturates, `first_err_idx` is still valid.

## Configuration
- `FILTER_BIST_FLUSH_EN` defined: `start` enters FLUSH. FLUSH drives `dut_in`=0 for `FLUSH_LEN` cycles with no comparison, then enters RUN. This clears the filter's internal state so results do not depend on history.
- `FILTER_BIST_FLUSH_EN` undefined: FLUSH is not built, `start` goes directly to RUN, and `FLUSH_LEN` is unused.

## Test plan
- Matched run: load `stim[i]`=i and `ref[i]`=i. Use a loopback DUT model that delays `dut_in` by `LATENCY`=6 cycles, with a zero initial pipeline. Pulse `start` → `done` 134 cycles later, `pass`=1, `err_count`=0, `first_err_idx`=all-ones.
- Single fault: same setup with `ref[10]` changed to 11'sh3FF → `pass`=0, `err_count`=1, `first_err_idx`=16.
- Saturation: `ERR_W`=4, all reference entries ≠ loopback output → `err_count`=15, `first_err_idx`=6.
- Protocol: assert `start` and a `load_en` write at j=50 → run is unaffected and the memory is unchanged. `start` in the DONE cycle is ignored; `start` one cycle later launches a new run.
- Reset mid-run: assert `reset` at j=70 → all outputs return to reset values within the same cycle. A later run with the same memories gives `pass`=1, so the memories survived.
- Flush (macro defined, `FLUSH_LEN`=25): preload the DUT model pipeline with non-zero values → `dut_in`=0 for 25 cycles, then `pass`=1. `done` arrives 159 cycles after `start`.

Source files
------------

// File: rtl/filter_bist.sv
// filter_bist: built-in self-test sequencer for the IIR filter datapath.
//
// Holds a stimulus memory and a reference memory, both loaded through a simple
// write port while idle. A run plays stim[0..DEPTH-1] followed by LATENCY zero
// samples into the filter. In every run cycle it compares the filter output
// against the reference, delayed by LATENCY. It reports pass/fail, a saturating
// mismatch count and the index of the first mismatch.
//
// Optional feature macro: FILTER_BIST_FLUSH_EN
//   When defined, an accepted start first drives FLUSH_LEN zero samples, with
//   no comparison, to clear the filter's internal state. The run follows.
//
// Ports:
//   clk, reset          clock (rising edge), asynchronous active-high reset
//   load_en/load_sel    memory write strobe / select (0 stimulus, 1 reference)
//   load_addr/load_data write address (>= DEPTH ignored) and data
//   start               single-cycle run request (ignored while busy)
//   dut_in              registered sample driven to the filter
//   dut_out             filter output under test
//   busy, done          run in progress / one-cycle end-of-run pulse
//   pass                result of the last completed run
//   err_count           saturating mismatch count
//   first_err_idx       compare index of the first mismatch (all-ones = none)

module filter_bist #(
    parameter int DATA_W    = 11,
    parameter int DEPTH     = 128,
    parameter int LATENCY   = 6,
    parameter int ERR_W     = 16,
    parameter int FLUSH_LEN = 25,
    parameter int AW        = $clog2(DEPTH + LATENCY)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic              load_sel,
    input  logic [AW-1:0]     load_addr,
    input  logic [DATA_W-1:0] load_data,
    input  logic              start,
    output logic [DATA_W-1:0] dut_in,
    input  logic [DATA_W-1:0] dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [ERR_W-1:0]  err_count,
    output logic [AW-1:0]     first_err_idx
);

    localparam int              MW      = $clog2(DEPTH);
    localparam logic [AW:0]     DEPTH_X = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]   LAT_A   = AW'(LATENCY);
    localparam logic [MW-1:0]   LAT_M   = MW'(LATENCY);
    localparam logic [AW-1:0]   LAST_J  = AW'(DEPTH + LATENCY - 1);

    if (DEPTH < 2 || LATENCY < 0 || LATENCY >= DEPTH || FLUSH_LEN < 1) begin : g_param_check
        $error("filter_bist: illegal parameter combination");
    end

`ifdef FILTER_BIST_FLUSH_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_FLUSH = 2'd1, S_RUN = 2'd2, S_DONE = 2'd3} state_t;
    localparam int FW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    logic [FW-1:0] flush_cnt_q, flush_cnt_d;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd2, S_DONE = 2'd3} state_t;
`endif

    state_t            state_q, state_d;
    logic [AW-1:0]     j_q, j_d;
    logic [DATA_W-1:0] dut_in_q, dut_in_d;
    logic [DATA_W-1:0] exp_q, exp_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic [ERR_W-1:0]  err_q, err_d;
    logic [AW-1:0]     first_q, first_d;

    logic [DATA_W-1:0] stim_mem [DEPTH];
    logic [DATA_W-1:0] ref_mem  [DEPTH];

    // Memories are written only while idle and are never reset, so a
    // mid-run reset leaves the loaded vectors intact.
    logic wr_ok;
    assign wr_ok = (state_q == S_IDLE) && load_en && ({1'b0, load_addr} < DEPTH_X);

    always_ff @(posedge clk) begin
        if (wr_ok && !load_sel) stim_mem[load_addr[MW-1:0]] <= load_data;
        if (wr_ok &&  load_sel) ref_mem[load_addr[MW-1:0]]  <= load_data;
    end

    // Sample and expected value for the index that becomes current at the
    // next edge: index 0 from IDLE/FLUSH, j_q+1 from RUN. The expected value
    // is registered next to dut_in so both describe the same index.
    logic [AW-1:0]     rd_j;
    logic [MW-1:0]     ref_i;
    logic [DATA_W-1:0] stim_rd, exp_rd;

    always_comb begin
        rd_j    = (state_q == S_RUN) ? j_q + AW'(1) : '0;
        ref_i   = rd_j[MW-1:0] - LAT_M;
        stim_rd = '0;
        exp_rd  = '0;
        if ({1'b0, rd_j} < DEPTH_X) stim_rd = stim_mem[rd_j[MW-1:0]];
        if (rd_j >= LAT_A)          exp_rd  = ref_mem[ref_i];
    end

    always_comb begin
        state_d  = state_q;
        j_d      = j_q;
        dut_in_d = dut_in_q;
        exp_d    = exp_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        pass_d   = pass_q;
        err_d    = err_q;
        first_d  = first_q;
`ifdef FILTER_BIST_FLUSH_EN
        flush_cnt_d = flush_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                dut_in_d = '0;
                if (start) begin
                    busy_d  = 1'b1;
                    pass_d  = 1'b0;
                    err_d   = '0;
                    first_d = '1;
                    j_d     = '0;
`ifdef FILTER_BIST_FLUSH_EN
                    state_d     = S_FLUSH;
                    flush_cnt_d = FW'(FLUSH_LEN - 1);
`else
                    state_d  = S_RUN;
                    dut_in_d = stim_rd;
                    exp_d    = exp_rd;
`endif
                end
            end
`ifdef FILTER_BIST_FLUSH_EN
            S_FLUSH: begin
                dut_in_d = '0;
                if (flush_cnt_q == '0) begin
                    state_d  = S_RUN;
                    dut_in_d = stim_rd;
                    exp_d    = exp_rd;
                end else begin
                    flush_cnt_d = flush_cnt_q - FW'(1);
                end
            end
`endif
            S_RUN: begin
                if (dut_out != exp_q) begin
                    if (err_q != '1) err_d = err_q + ERR_W'(1);
                    if (first_q == '1) first_d = j_q;
                end
                if (j_q == LAST_J) begin
                    state_d  = S_DONE;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                    dut_in_d = '0;
                    // err_d already includes the final compare
                    pass_d   = (err_d == '0);
                end else begin
                    j_d      = j_q + AW'(1);
                    dut_in_d = stim_rd;
                    exp_d    = exp_rd;
                end
            end
            S_DONE: begin
                state_d  = S_IDLE;
                dut_in_d = '0;
            end
            default: begin
                state_d  = S_IDLE;
                busy_d   = 1'b0;
                dut_in_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            j_q      <= '0;
            dut_in_q <= '0;
            exp_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
            err_q    <= '0;
            first_q  <= '1;
`ifdef FILTER_BIST_FLUSH_EN
            flush_cnt_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            j_q      <= j_d;
            dut_in_q <= dut_in_d;
            exp_q    <= exp_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            pass_q   <= pass_d;
            err_q    <= err_d;
            first_q  <= first_d;
`ifdef FILTER_BIST_FLUSH_EN
            flush_cnt_q <= flush_cnt_d;
`endif
        end
    end

    assign dut_in        = dut_in_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign err_count     = err_q;
    assign first_err_idx = first_q;

endmodule

// File: tb/tb_filter_bist.sv
// Bench for filter_bist: two instances (16-bit and 4-bit error counters)
// share all control inputs. Each one drives its own loopback filter stand-in
// that delays dut_in by LATENCY cycles. A behavioural model predicts every
// output cycle by cycle, and hand-computed literals pin the key results.

module tb_filter_bist;

    localparam int D  = 128;
    localparam int L  = 6;
    localparam int AW = 8;
    localparam int DW = 11;
    localparam int RUN_LEN = D + L;
`ifdef FILTER_BIST_FLUSH_EN
    localparam int F = 25;
    localparam int DONE_LAT = 159;
`else
    localparam int F = 0;
    localparam int DONE_LAT = 134;
`endif

    logic          clk, reset, load_en, load_sel, start;
    logic [AW-1:0] load_addr;
    logic [DW-1:0] load_data;
    logic [DW-1:0] din_a, dout_a, din_b, dout_b;
    logic          busy_a, done_a, pass_a, busy_b, done_b, pass_b;
    logic [15:0]   err_a;
    logic [3:0]    err_b;
    logic [AW-1:0] first_a, first_b;

    filter_bist #(.DATA_W(DW), .DEPTH(D), .LATENCY(L), .ERR_W(16), .FLUSH_LEN(25)) u_main (
        .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .start(start),
        .dut_in(din_a), .dut_out(dout_a), .busy(busy_a), .done(done_a),
        .pass(pass_a), .err_count(err_a), .first_err_idx(first_a));

    filter_bist #(.DATA_W(DW), .DEPTH(D), .LATENCY(L), .ERR_W(4), .FLUSH_LEN(25)) u_sat (
        .clk(clk), .reset(reset), .load_en(load_en), .load_sel(load_sel),
        .load_addr(load_addr), .load_data(load_data), .start(start),
        .dut_in(din_b), .dut_out(dout_b), .busy(busy_b), .done(done_b),
        .pass(pass_b), .err_count(err_b), .first_err_idx(first_b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, req);
        end
    endtask

    // ---------------- loopback filter stand-ins ----------------
    logic [DW-1:0] pipe_a [L];
    logic [DW-1:0] pipe_b [L];
    assign dout_a = pipe_a[L-1];
    assign dout_b = pipe_b[L-1];

    // ---------------- behavioural model ----------------
    int            m_k;       // -1 idle, else edges since start was accepted
    int            m_err;     // unsaturated mismatch count
    int            m_first;   // -1 = no mismatch yet
    bit            m_pass;
    logic [DW-1:0] m_stim [D];
    logic [DW-1:0] m_ref  [D];

    function automatic int drv(input int j);
        return (j < D) ? int'(m_stim[j]) : 0;
    endfunction

    // Loopback output seen in compare cycle j, with a zero pipeline history.
    function automatic int out_at(input int j);
        return (j >= L) ? drv(j - L) : 0;
    endfunction

    function automatic int exp_at(input int j);
        return (j < L) ? 0 : int'(m_ref[j - L]);
    endfunction

    initial begin
        for (int i = 0; i < L; i++) begin
            pipe_a[i] = '0;
            pipe_b[i] = '0;
        end
    end

    always @(posedge clk) begin
`ifdef FILTER_BIST_FLUSH_EN
        if (start && m_k < 0 && !reset) begin
            for (int i = 0; i < L; i++) begin
                pipe_a[i] <= DW'(11'h123 + i);
                pipe_b[i] <= DW'(11'h2A0 + i);
            end
        end else begin
`else
        begin
`endif
            pipe_a[0] <= din_a;
            pipe_b[0] <= din_b;
            for (int i = 1; i < L; i++) begin
                pipe_a[i] <= pipe_a[i-1];
                pipe_b[i] <= pipe_b[i-1];
            end
        end
    end

    always @(posedge clk or posedge reset) begin : model
        int k, e, f, j;
        bit p;
        if (reset) begin
            m_k     <= -1;
            m_err   <= 0;
            m_first <= -1;
            m_pass  <= 1'b0;
        end else begin
            k = m_k; e = m_err; f = m_first; p = m_pass;
            if (k < 0) begin
                if (load_en && int'(load_addr) < D) begin
                    if (load_sel) m_ref[load_addr]  <= load_data;
                    else          m_stim[load_addr] <= load_data;
                end
                if (start) begin
                    k = 0; e = 0; f = -1; p = 1'b0;
                end
            end else begin
                if (k >= F && k < F + RUN_LEN) begin
                    j = k - F;
                    if (out_at(j) != exp_at(j)) begin
                        e++;
                        if (f < 0) f = j;
                    end
                end
                k++;
                if (k == F + RUN_LEN) p = (e == 0);
                else if (k > F + RUN_LEN) k = -1;
            end
            m_k <= k; m_err <= e; m_first <= f; m_pass <= p;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin : compare
        int eb, ed, edin, ef;
        eb   = (m_k >= 0 && m_k < F + RUN_LEN) ? 1 : 0;
        ed   = (m_k == F + RUN_LEN) ? 1 : 0;
        edin = (m_k >= F && m_k < F + RUN_LEN) ? drv(m_k - F) : 0;
        ef   = (m_first < 0) ? 255 : m_first;
        chk("busy_a", 32'(busy_a), eb);
        chk("done_a", 32'(done_a), ed);
        chk("din_a", 32'(din_a), edin);
        chk("pass_a", 32'(pass_a), 32'(m_pass));
        chk("err_a", 32'(err_a), (m_err > 65535) ? 65535 : m_err);
        chk("first_a", 32'(first_a), ef);
        chk("busy_b", 32'(busy_b), eb);
        chk("done_b", 32'(done_b), ed);
        chk("din_b", 32'(din_b), edin);
        chk("pass_b", 32'(pass_b), 32'(m_pass));
        chk("err_b", 32'(err_b), (m_err > 15) ? 15 : m_err);
        chk("first_b", 32'(first_b), ef);
    end

    // ---------------- stimulus ----------------
    task automatic wr(input bit s, input int a, input int d);
        @(negedge clk);
        load_en   = 1'b1;
        load_sel  = s;
        load_addr = AW'(a);
        load_data = DW'(d);
    endtask

    task automatic wr_end();
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic launch();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic reset_literals(input string tag);
        chk({tag, "_din"},   32'(din_a),   0);
        chk({tag, "_busy"},  32'(busy_a),  0);
        chk({tag, "_done"},  32'(done_a),  0);
        chk({tag, "_pass"},  32'(pass_a),  0);
        chk({tag, "_err"},   32'(err_a),   0);
        chk({tag, "_first"}, 32'(first_a), 255);
        chk({tag, "_err_b"}, 32'(err_b),   0);
    endtask

    // Counts edges after the accepting edge until done is seen. inj injects a
    // start plus a stimulus write while busy; rst_at asserts reset mid-cycle.
    task automatic wait_done(input int inj, input int rst_at, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == inj) begin
                start = 1'b1; load_en = 1'b1; load_sel = 1'b0;
                load_addr = AW'(50); load_data = DW'(11'h155);
            end
            if (cyc == inj + 1) begin
                start = 1'b0; load_en = 1'b0;
            end
            if (cyc == rst_at) begin
                #2 reset = 1'b1;
                #1 reset_literals("midrun_rst");
                @(negedge clk);
                reset = 1'b0;
                return;
            end
        end while (!done_a && cyc < 400);
        if (!done_a) chk("done_timeout", 32'(cyc), DONE_LAT);
    endtask

    int cyc;

    initial begin
        reset = 1'b1; load_en = 1'b0; load_sel = 1'b0; start = 1'b0;
        load_addr = '0; load_data = '0;
        repeat (3) @(negedge clk);
        reset_literals("por");
        reset = 1'b0;

        // matched vectors, plus out-of-range writes that must be dropped
        for (int i = 0; i < D; i++) begin
            wr(1'b0, i, i);
            wr(1'b1, i, i);
        end
        wr(1'b0, 128, 11'h2AA);
        wr(1'b1, 200, 11'h155);
        wr_end();
        repeat (8) @(negedge clk);

        launch();
        wait_done(-1, -1, cyc);
        chk("match_latency", 32'(cyc), DONE_LAT);
        chk("match_pass", 32'(pass_a), 1);
        chk("match_err", 32'(err_a), 0);
        chk("match_first", 32'(first_a), 255);
        chk("match_pass_b", 32'(pass_b), 1);

        // single fault
        repeat (3) @(negedge clk);
        wr(1'b1, 10, 11'h3FF);
        wr_end();
        launch();
        wait_done(-1, -1, cyc);
        chk("fault_pass", 32'(pass_a), 0);
        chk("fault_err", 32'(err_a), 1);
        chk("fault_first", 32'(first_a), 16);

        // protocol: start + write while busy, start in DONE, then restart
        repeat (3) @(negedge clk);
        wr(1'b1, 10, 10);
        wr_end();
        launch();
        wait_done(F + 50, -1, cyc);
        chk("proto_latency", 32'(cyc), DONE_LAT);
        chk("proto_pass", 32'(pass_a), 1);
        start = 1'b1;                 // DONE cycle: ignored
        @(negedge clk);
        chk("done_start_ignored", 32'(busy_a), 0);
        @(negedge clk);               // following IDLE cycle: accepted
        start = 1'b0;
        chk("restart_busy", 32'(busy_a), 1);
        wait_done(-1, -1, cyc);
        chk("restart_latency", 32'(cyc), DONE_LAT);
        chk("restart_pass", 32'(pass_a), 1);

        // reset mid-run, then memories must still be intact
        repeat (3) @(negedge clk);
        launch();
        wait_done(-1, F + 70, cyc);
        repeat (8) @(negedge clk);
        launch();
        wait_done(-1, -1, cyc);
        chk("after_rst_pass", 32'(pass_a), 1);
        chk("after_rst_err", 32'(err_a), 0);

        // every reference entry differs from the loopback output
        repeat (3) @(negedge clk);
        for (int i = 0; i < D; i++) wr(1'b1, i, i + 1);
        wr_end();
        launch();
        wait_done(-1, -1, cyc);
        chk("sat_err_a", 32'(err_a), 128);
        chk("sat_first_a", 32'(first_a), 6);
        chk("sat_err_b", 32'(err_b), 15);
        chk("sat_first_b", 32'(first_b), 6);
        chk("sat_pass_b", 32'(pass_b), 0);
        repeat (4) @(negedge clk);
        chk("sat_hold_b", 32'(err_b), 15);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got time %0t, expected < 500000", $time);
        $fatal(1, "watchdog");
    end

endmodule
